// File: rtl/usr_cmd_sequencer_if.sv
// Command channel between a requester and the usr command sequencer.
// The master drives a command under valid/ready; the slave accepts one command at a time.
interface usr_cmd_sequencer_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;
    logic             cmd_rot;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_count,
        output cmd_fill,
        output cmd_rot,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_count,
        input  cmd_fill,
        input  cmd_rot,
        output cmd_ready
    );
endinterface

// File: rtl/usr_cmd_sequencer.sv
// Sequences load and N-step shift/rotate commands onto a universal shift register's
// select/parallel/serial inputs, one command at a time, with a one-cycle done pulse.
module usr_cmd_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    usr_cmd_sequencer_if.slave   cmd,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     usr_q,
    output logic [WIDTH-1:0]     usr_i,
    output logic [1:0]           usr_select,
    output logic                 usr_s_left,
    output logic                 usr_s_right,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    localparam logic [1:0] OpNop  = 2'b00;
    localparam logic [1:0] OpShr  = 2'b01;
    localparam logic [1:0] OpShl  = 2'b10;
    localparam logic [1:0] OpLoad = 2'b11;

    state_e           state_q;
    logic [1:0]       op_q;
    logic             fill_q;
    logic             rot_q;
    logic [CNT_W-1:0] count_q;

    assign cmd.cmd_ready = (state_q == StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= OpNop;
            fill_q     <= 1'b0;
            rot_q      <= 1'b0;
            count_q    <= '0;
            usr_i      <= '0;
            usr_select <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd.cmd_valid) begin
                        op_q    <= cmd.cmd_op;
                        fill_q  <= cmd.cmd_fill;
                        rot_q   <= cmd.cmd_rot;
                        count_q <= cmd.cmd_count;
                        busy    <= 1'b1;
                        aborted <= 1'b0;
                        if (cmd.cmd_op == OpLoad) begin
                            state_q    <= StLoad;
                            usr_select <= OpLoad;
                            usr_i      <= cmd.cmd_data;
                        end else if (cmd.cmd_op == OpNop || cmd.cmd_count == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            // Shift op encodings coincide with the usr select codes.
                            state_q    <= StShift;
                            usr_select <= cmd.cmd_op;
                        end
                    end
                end
                StLoad: begin
                    state_q    <= StDone;
                    usr_select <= 2'b00;
                    usr_i      <= '0;
                    done       <= 1'b1;
                end
                StShift: begin
                    count_q <= count_q - 1'b1;
                    // The edge that sees abort still shifts; a final-step abort is a normal finish.
                    if (count_q == CNT_W'(1) || abort) begin
                        state_q    <= StDone;
                        usr_select <= 2'b00;
                        done       <= 1'b1;
                        aborted    <= (count_q != CNT_W'(1));
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    aborted <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Rotate feeds the end bit back combinationally so each step sees the current usr_q.
    always_comb begin
        usr_s_left  = 1'b0;
        usr_s_right = 1'b0;
        if (state_q == StShift) begin
            if (op_q == OpShr) begin
                usr_s_right = rot_q ? usr_q[0] : fill_q;
            end else if (op_q == OpShl) begin
                usr_s_left = rot_q ? usr_q[WIDTH-1] : fill_q;
            end
        end
    end

endmodule
